// File: rtl/time_set_ctrl_pkg.sv
// time_set_ctrl_pkg: state encodings, blink codes and field limits shared by the clock-setting block.
package time_set_ctrl_pkg;
  typedef enum logic [1:0] {
    RUN      = 2'd0,
    SET_HOUR = 2'd1,
    SET_MIN  = 2'd2,
    SET_SEC  = 2'd3
  } state_t;
  localparam logic [1:0] BLINK_NONE = 2'b00;
  localparam logic [1:0] BLINK_SEC  = 2'b01;
  localparam logic [1:0] BLINK_MIN  = 2'b10;
  localparam logic [1:0] BLINK_HOUR = 2'b11;
  localparam logic [7:0] SEC_MAX  = 8'd59;
  localparam logic [7:0] MIN_MAX  = 8'd59;
  localparam logic [7:0] HOUR_MAX = 8'd23;
endpackage

// File: rtl/time_set_ctrl_field_counter.sv
// field_counter: mod-(MAX+1) up/down counter; carry_in advances with carry-out, inc/dec edit without carry.
module field_counter #(
  parameter logic [7:0] MAX = 8'd59
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       inc,
  input  logic       dec,
  input  logic       carry_in,
  output logic [7:0] value,
  output logic       carry_out
);
  logic [7:0] up, down;
  assign up        = value == MAX ? 8'd0 : value + 8'd1;
  assign down      = value == 8'd0 ? MAX : value - 8'd1;
  assign carry_out = carry_in && value == MAX;
  always_ff @(posedge clk)
    if (!rst_n) value <= 8'd0;
    else if (carry_in || (inc && !dec)) value <= up;
    else if (dec && !inc) value <= down;
endmodule

// File: rtl/time_set_ctrl.sv
// time_set_ctrl: running HH:MM:SS clock with a key-driven set mode; prescaler and mode FSM live here.
module time_set_ctrl
  import time_set_ctrl_pkg::*;
#(
  parameter logic [25:0] T1S = 26'd49_999_999
) (
  input  logic        CLK,
  input  logic        RSTn,
  input  logic        Key_Mode,
  input  logic        Key_Inc,
  input  logic        Key_Dec,
  output logic [23:0] Number_Data,
  output logic [1:0]  Blink,
  output logic        Day_Wrap
);
  state_t state, state_next;
  logic [1:0] blink_next;
  logic [25:0] pre;
  logic [7:0] sec, min, hour;
  logic tick, edit_inc, edit_dec, c_sec, c_min, c_hour;
  assign tick     = state == RUN && pre == T1S;
  assign edit_inc = Key_Inc && !Key_Mode;
  assign edit_dec = Key_Dec && !Key_Mode;
  always_ff @(posedge CLK)
    if (!RSTn) begin
      state <= RUN;
      Blink <= BLINK_NONE;
    end else begin
      state <= state_next;
      Blink <= blink_next;
    end
  always_comb
    state_next = !Key_Mode         ? state    :
                 state == RUN      ? SET_HOUR :
                 state == SET_HOUR ? SET_MIN  :
                 state == SET_MIN  ? SET_SEC  : RUN;
  always_comb
    blink_next = state_next == RUN      ? BLINK_NONE :
                 state_next == SET_HOUR ? BLINK_HOUR :
                 state_next == SET_MIN  ? BLINK_MIN  : BLINK_SEC;
  // Prescaler is parked at 0 while editing so leaving set mode starts a full second.
  always_ff @(posedge CLK)
    if (!RSTn) begin
      pre      <= 26'd0;
      Day_Wrap <= 1'b0;
    end else begin
      pre      <= (state != RUN || tick) ? 26'd0 : pre + 26'd1;
      Day_Wrap <= c_hour;
    end
  field_counter #(.MAX(SEC_MAX)) u_sec (
    .clk(CLK), .rst_n(RSTn),
    .inc(state == SET_SEC && edit_inc), .dec(state == SET_SEC && edit_dec),
    .carry_in(tick), .value(sec), .carry_out(c_sec)
  );
  field_counter #(.MAX(MIN_MAX)) u_min (
    .clk(CLK), .rst_n(RSTn),
    .inc(state == SET_MIN && edit_inc), .dec(state == SET_MIN && edit_dec),
    .carry_in(c_sec), .value(min), .carry_out(c_min)
  );
  field_counter #(.MAX(HOUR_MAX)) u_hour (
    .clk(CLK), .rst_n(RSTn),
    .inc(state == SET_HOUR && edit_inc), .dec(state == SET_HOUR && edit_dec),
    .carry_in(c_min), .value(hour), .carry_out(c_hour)
  );
  assign Number_Data = {hour, min, sec};
endmodule

// File: tb/tb_time_set_ctrl.sv
// tb_time_set_ctrl: scoreboard bench; a seconds-of-day model predicts each cycle's outputs.
module tb_time_set_ctrl;
  localparam int T1S = 3;
  logic CLK = 1'b0, RSTn = 1'b0, Key_Mode = 1'b0, Key_Inc = 1'b0, Key_Dec = 1'b0;
  logic [23:0] Number_Data;
  logic [1:0] Blink;
  logic Day_Wrap;
  typedef struct packed {
    logic [23:0] nd;
    logic [1:0]  bl;
    logic        dw;
  } exp_t;
  exp_t q[$];
  int checks = 0, errors = 0, wraps_seen = 0;
  int m_mode = 0, m_h = 0, m_m = 0, m_s = 0, m_pre = 0;
  bit m_dw = 1'b0;
  always #5 CLK = ~CLK;
  time_set_ctrl #(.T1S(26'd3)) dut (
    .CLK(CLK), .RSTn(RSTn), .Key_Mode(Key_Mode), .Key_Inc(Key_Inc), .Key_Dec(Key_Dec),
    .Number_Data(Number_Data), .Blink(Blink), .Day_Wrap(Day_Wrap)
  );
  task automatic step(input bit rstn, input bit km, input bit ki, input bit kd);
    exp_t e;
    int t, d;
    @(negedge CLK);
    RSTn = rstn; Key_Mode = km; Key_Inc = ki; Key_Dec = kd;
    m_dw = 1'b0;
    if (!rstn) begin
      m_mode = 0; m_h = 0; m_m = 0; m_s = 0; m_pre = 0;
    end else begin
      if (m_mode == 0) begin
        if (m_pre == T1S) begin
          m_pre = 0;
          t = m_h * 3600 + m_m * 60 + m_s + 1;
          if (t == 86400) begin t = 0; m_dw = 1'b1; end
          m_h = t / 3600; m_m = (t / 60) % 60; m_s = t % 60;
        end else m_pre++;
      end else begin
        m_pre = 0;
        if (!km && ki != kd) begin
          d = ki ? 1 : -1;
          if (m_mode == 1) m_h = (m_h + d + 24) % 24;
          if (m_mode == 2) m_m = (m_m + d + 60) % 60;
          if (m_mode == 3) m_s = (m_s + d + 60) % 60;
        end
      end
      if (km) m_mode = (m_mode + 1) % 4;
    end
    e.nd = {8'(m_h), 8'(m_m), 8'(m_s)};
    e.bl = m_mode == 0 ? 2'b00 : m_mode == 1 ? 2'b11 : m_mode == 2 ? 2'b10 : 2'b01;
    e.dw = m_dw;
    q.push_back(e);
  endtask
  task automatic idle(input int n);
    repeat (n) step(1, 0, 0, 0);
  endtask
  always begin
    exp_t e;
    @(posedge CLK);
    #1;
    if (q.size() > 0) begin
      e = q.pop_front();
      checks += 3;
      if (Number_Data !== e.nd) begin
        errors++;
        $display("FAIL number_data at %0t: got %h expected %h", $time, Number_Data, e.nd);
      end
      if (Blink !== e.bl) begin
        errors++;
        $display("FAIL blink at %0t: got %b expected %b", $time, Blink, e.bl);
      end
      if (Day_Wrap !== e.dw) begin
        errors++;
        $display("FAIL day_wrap at %0t: got %b expected %b", $time, Day_Wrap, e.dw);
      end
      if (e.dw && Day_Wrap === 1'b1) wraps_seen++;
    end
  end
  initial begin
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    step(0, 1, 1, 0);
    // Preload 23:59:59 by decrementing each field from 0, then run into the rollover.
    step(1, 1, 0, 0); step(1, 0, 0, 1);
    step(1, 1, 0, 0); step(1, 0, 0, 1);
    step(1, 1, 0, 0); step(1, 0, 0, 1);
    step(1, 1, 0, 0);
    idle(6);
    step(1, 1, 0, 0); step(1, 0, 0, 1); step(1, 0, 1, 0);
    step(1, 1, 0, 0);
    for (int i = 0; i < 60 && m_m != 59; i++) step(1, 0, 0, 1);
    step(1, 0, 1, 0);
    idle(20);
    step(1, 1, 0, 0);
    step(1, 0, 1, 1);
    step(1, 1, 1, 0);
    idle(6);
    step(1, 0, 1, 0);
    idle(5);
    // Build 12:34:56, revisit SET_MIN, then abandon the edit with reset.
    step(0, 0, 0, 0);
    step(1, 1, 0, 0); repeat (12) step(1, 0, 1, 0);
    step(1, 1, 0, 0); repeat (34) step(1, 0, 1, 0);
    step(1, 1, 0, 0); repeat (56) step(1, 0, 1, 0);
    step(1, 1, 0, 0);
    step(1, 1, 0, 0); step(1, 1, 0, 0);
    step(0, 0, 1, 0);
    idle(3);
    for (int i = 0; i < 3000; i++)
      step($urandom_range(0, 299) != 0, $urandom_range(0, 15) == 0,
           $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0);
    repeat (3) @(posedge CLK);
    #2;
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expected 0", q.size());
    end
    checks++;
    if (wraps_seen == 0) begin
      errors++;
      $display("FAIL day_wrap_seen: got %0d pulses expected at least 1", wraps_seen);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
